// File: rtl/pdm_decimator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_decimator
// Brief    : PDM microphone receiver. Generates the mic bit clock, samples
//            the 1-bit stream and decimates it to signed PCM through a
//            3rd-order CIC (differential delay 1) with saturating scaling.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_decimator #(
    parameter int HALF_PERIOD = 16,
    parameter int DECIM       = 64,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        mic_data_in,
    output logic                        mic_clk_out,
    output logic signed [OUT_WIDTH-1:0] sample_out,
    output logic                        sample_valid_out
);

    // CIC register growth is 3*log2(R) bits; one extra bit keeps +R^3 positive.
    localparam int c_log2_r = $clog2(DECIM);
    localparam int c_w      = 3 * c_log2_r + 2;
    localparam int c_shift  = 3 * c_log2_r + 1 - OUT_WIDTH;
    localparam int c_div_w  = $clog2(HALF_PERIOD);
    localparam int c_dec_w  = c_log2_r;

    localparam logic [c_div_w-1:0]          c_div_last = c_div_w'(HALF_PERIOD - 1);
    localparam logic [c_dec_w-1:0]          c_dec_last = c_dec_w'(DECIM - 1);
    localparam logic signed [c_w-1:0]       c_pos_one  = c_w'(1);
    localparam logic signed [c_w-1:0]       c_neg_one  = '1;
    localparam logic signed [c_w-1:0]       c_sat_max  = c_w'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [c_w-1:0]       c_sat_min  = ~c_sat_max;
    localparam logic signed [OUT_WIDTH-1:0] c_out_max  = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] c_out_min  = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic [c_div_w-1:0]          r_div_cnt;
    logic                        r_mic_clk;
    logic                        r_sync1;
    logic                        r_sync2;
    logic                        w_tick;
    logic signed [c_w-1:0]       w_x;
    logic signed [c_w-1:0]       r_int1;
    logic signed [c_w-1:0]       r_int2;
    logic signed [c_w-1:0]       r_int3;
    logic [c_dec_w-1:0]          r_dec_cnt;
    logic                        r_dec_stb;
    logic signed [c_w-1:0]       r_comb1;
    logic signed [c_w-1:0]       r_comb2;
    logic signed [c_w-1:0]       r_comb3;
    logic signed [c_w-1:0]       r_dly1;
    logic signed [c_w-1:0]       r_dly2;
    logic signed [c_w-1:0]       r_dly3;
    logic                        r_v1;
    logic                        r_v2;
    logic                        r_v3;
    logic signed [c_w-1:0]       w_scaled;
    logic signed [OUT_WIDTH-1:0] w_out;
    logic [1:0]                  r_warm;
    logic signed [OUT_WIDTH-1:0] r_sample;
    logic                        r_valid;

    // Bit tick: last cycle of the high phase, i.e. just before the falling edge.
    assign w_tick = (r_div_cnt == c_div_last) && r_mic_clk;
    // Bipolar mapping of the synchronized bit: 1 -> +1, 0 -> -1.
    assign w_x    = r_sync2 ? c_pos_one : c_neg_one;

    // Mic clock divider: toggle on every counter wrap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_cnt <= '0;
            r_mic_clk <= 1'b0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
            r_mic_clk <= ~r_mic_clk;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous mic data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mic_data_in;
            r_sync2 <= r_sync1;
        end
    end

    // Integrator cascade and block counter; each stage adds the previous
    // stage's old value, wrap-around is harmless because the combs undo it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_int1    <= '0;
            r_int2    <= '0;
            r_int3    <= '0;
            r_dec_cnt <= '0;
            r_dec_stb <= 1'b0;
        end else begin
            r_dec_stb <= 1'b0;
            if (w_tick) begin
                r_int1 <= r_int1 + w_x;
                r_int2 <= r_int2 + r_int1;
                r_int3 <= r_int3 + r_int2;
                if (r_dec_cnt == c_dec_last) begin
                    r_dec_cnt <= '0;
                    r_dec_stb <= 1'b1;
                end else begin
                    r_dec_cnt <= r_dec_cnt + c_dec_w'(1);
                end
            end
        end
    end

    // Comb pipeline, one stage per cycle, advanced by a travelling valid bit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_comb1 <= '0;
            r_comb2 <= '0;
            r_comb3 <= '0;
            r_dly1  <= '0;
            r_dly2  <= '0;
            r_dly3  <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
        end else begin
            r_v1 <= r_dec_stb;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_dec_stb) begin
                r_comb1 <= r_int3 - r_dly1;
                r_dly1  <= r_int3;
            end
            if (r_v1) begin
                r_comb2 <= r_comb1 - r_dly2;
                r_dly2  <= r_comb1;
            end
            if (r_v2) begin
                r_comb3 <= r_comb2 - r_dly3;
                r_dly3  <= r_comb2;
            end
        end
    end

    assign w_scaled = r_comb3 >>> c_shift;

    // Saturate the scaled comb output into the PCM range (+R^3 clips to max).
    always_comb begin
        w_out = w_scaled[OUT_WIDTH-1:0];
        if (w_scaled > c_sat_max) begin
            w_out = c_out_max;
        end else if (w_scaled < c_sat_min) begin
            w_out = c_out_min;
        end
    end

    // Output register: swallow the first three results while the filter fills.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_warm   <= 2'd0;
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_v3) begin
                if (r_warm != 2'd3) begin
                    r_warm <= r_warm + 2'd1;
                end else begin
                    r_sample <= w_out;
                    r_valid  <= 1'b1;
                end
            end
        end
    end

    assign mic_clk_out      = r_mic_clk;
    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;

endmodule
`default_nettype wire

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart of the audio PDM output path: generates the bit clock for an external PDM MEMS microphone, samples its 1-bit stream and converts it into signed PCM samples with a 3rd-order CIC decimation filter. It sits in the `clk_98_3mhz` domain and feeds microphone audio to the vocoder/synthesizer datapath. With default parameters it produces a 3.07 MHz mic clock and about 48 kHz, 16-bit samples.

## Interface
- `HALF_PERIOD`, 16: mic clock half-period in `clk_in` cycles; legal values are 3 and above.
- `DECIM`, 64: decimation ratio R; must be a power of 2 and at least 4.
- `OUT_WIDTH`, 16: PCM sample width; requires 3·log2(DECIM)+1 ≥ OUT_WIDTH.
- `clk_in` in 1: system clock, `clk_98_3mhz`.
- `rst_in` in 1: synchronous reset, active-high.
- `mic_data_in` in 1: PDM data from the microphone, asynchronous to `clk_in`.
- `mic_clk_out` out 1: generated microphone bit clock.
- `sample_out` out OUT_WIDTH, signed: decimated PCM sample.
- `sample_valid_out` out 1: one-cycle pulse marking a new `sample_out`.

## Operation
- **Clock divider.** A counter runs 0..HALF_PERIOD-1. `mic_clk_out` toggles in the cycle the counter wraps. The mic clock period is 2·HALF_PERIOD.
- **Input synchronizer.** `mic_data_in` passes through a 2-flop synchronizer.
- **Bit tick.** The tick asserts in the cycle where the counter equals HALF_PERIOD-1 and `mic_clk_out`=1, which is the cycle before the falling edge.
  - On the tick, the synchronized bit is captured.
  - A 1 maps to +1 and a 0 maps to -1.
- **Integrators.** Three cascaded, registered integrators of width W = 3·log2(DECIM)+2 bits, two's complement.
  - They update one cycle after each tick, each adding the previous stage's old value: int1+=x, int2+=int1, int3+=int2.
  - Wrap-around is intended and never saturates; modular arithmetic makes the comb result exact.
- **Decimation.** A counter counts updates 0..DECIM-1. When it wraps, int3 is latched as the decimated value.
- **Combs.** Three comb stages (differential delay 1), pipelined one stage per cycle, each computing y = in − in_prev, all W bits wide.
- **Output scaling.**
  - comb3 is arithmetic-shifted right by SHIFT = 3·log2(DECIM)+1−OUT_WIDTH.
  - The result saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Full-scale positive density (+R³) maps to the max code; full-scale negative density maps to the min code.
- **Warm-up.** The first 3 decimated results after reset are computed but suppressed: `sample_valid_out` stays 0 and `sample_out` holds 0. The 4th result is the first valid sample.
- **Output hold.** `sample_out` holds its value between pulses.

## Timing
- **Reset values.** `mic_clk_out`=0, `sample_out`=0, `sample_valid_out`=0. All counters, synchronizer flops, integrators, comb delays and the warm-up count are 0.
- **Mic clock after reset.** The first `mic_clk_out` rise occurs HALF_PERIOD cycles after the first cycle with `rst_in`=0.
- **Latency.** Relative to tick cycle T of the bit that completes a block:
  - T+1: integrators update and the decimation strobe fires.
  - T+2, T+3, T+4: comb1, comb2, comb3.
  - T+5: `sample_out` is registered and `sample_valid_out`=1 for exactly one cycle.
- **Throughput.** Exactly one valid pulse every DECIM·2·HALF_PERIOD cycles (2048 with defaults). Pulses never overlap because HALF_PERIOD ≥ 3.
- **Input delay.** Data sampled at tick T reflects `mic_data_in` as it was 2 cycles earlier.
- **Reset mid-operation.**
  - On the cycle after `rst_in` is seen high, all outputs return to their reset values.
  - An in-flight comb pipeline result is discarded; no valid pulse may emerge from pre-reset data.
  - Warm-up restarts.
- **No backpressure.** The consumer must accept every pulse.

## Test plan
- **Reset and clock generation.** Hold reset 10 cycles, then release.
  - `mic_clk_out` stays 0 for 16 cycles, then runs with period 32 and 50% duty.
  - `sample_valid_out` stays 0 until the 4th block.
- **Constant 1 input.** Drive `mic_data_in`=1 continuously.
  - Every valid sample from the 2nd onward equals 32767.
  - Valid pulses are spaced exactly 2048 cycles apart.
- **Constant 0 input.** Drive `mic_data_in`=0 continuously.
  - Every valid sample from the 2nd onward equals −32768.
- **Pattern inputs.** Drive patterns synchronized to the bit ticks. In each case, check valid samples from the 2nd onward.
  - Alternating 1,0: `sample_out`=0 exactly.
  - Repeating 1,0,0,0: `sample_out`=−16384.
  - Repeating 1,1,1,0: `sample_out`=+16384.
- **Reset mid-operation.** Assert `rst_in` 3 cycles after a block-completing tick, i.e. while the comb pipeline is busy.
  - No valid pulse occurs afterwards from that data.
  - Outputs read 0 the next cycle.
  - The first post-reset valid pulse is the 4th block.
- **Latency and parameter sweep.** Measure the cycle from the block-completing tick to the `sample_valid_out` pulse: it must be exactly 5.
  - Repeat the constant-1 test with HALF_PERIOD=3, DECIM=4, OUT_WIDTH=7: output is 63, with a pulse every 24 cycles.
